// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t : FSM state encoding (IDLE, RUN, DONE; 2'b11 is illegal)
//   clog2   : constant function used to size the bit counter
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Ceiling log2. The result is never smaller than 1, so a counter
   // built from it always has at least one bit.
   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return (res < 1) ? 1 : res;
   endfunction

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: x - y - bin.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bo   : borrow out
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bin;
   assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE; a/b captured on accept
//   a, b       : minuend, subtrahend
//   busy       : high while the bits are being processed (RUN)
//   done       : one-cycle pulse when diff/bout are updated
//   diff, bout : result and unsigned borrow-out, held until next result
//   ovf        : signed overflow, present only with SERIAL_SUB_SIGNED_OVF_EN
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = clog2(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   res_sh;
   logic [CNT_W-1:0]   cnt;
   logic               borrow;
   logic               cell_d;
   logic               cell_bo;
   logic               last_bit;
   logic [WIDTH-1:0]   res_nxt;

   full_subtractor u_cell (
      .x   (a_sh[0]),
      .y   (b_sh[0]),
      .bin (borrow),
      .d   (cell_d),
      .bo  (cell_bo)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   // Result fills from the top so that after WIDTH shifts bit 0 sits at the LSB.
   assign res_nxt  = {cell_d, res_sh[WIDTH-1:1]};

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (last_bit) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;  // illegal 2'b11 recovers
      endcase
   end

   // NOTE: the shift registers are reset along with the control state even
   // though their contents are overwritten on every accepted start; this
   // keeps the whole datapath deterministic after a mid-operation abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  cnt    <= '0;
                  borrow <= 1'b0;
               end
            end
            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_nxt;
               borrow <= cell_bo;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
                  diff <= res_nxt;
                  bout <= cell_bo;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                  // On the last bit the cell sees the operand sign bits and
                  // produces the result sign bit.
                  ovf  <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). Stimulus pushes the
// expected result and the edge index at which done must appear into a
// queue; an independent monitor pops and compares on every done pulse.
// Honours SERIAL_SUB_SIGNED_OVF_EN for the ovf port.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             bout;
      logic             ovf;
      int               cyc;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic             ovf;
`endif

   exp_t q[$];
   int   checks;
   int   errors;
   int   cyc;
   int   accepts;
   int   dones;
   int   busy_cnt;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a_in),
      .b     (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic.
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int when);
      exp_t e;
      int   sd;
      e.diff = WIDTH'(x - y);
      e.bout = (x < y);
      sd     = int'($signed(x)) - int'($signed(y));
      e.ovf  = (sd > 127) || (sd < -128);
      e.cyc  = when;
      return e;
   endfunction

   // Monitor: one comparison set per done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0;
      end else if (done) begin
         check("done_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("diff", 32'(diff), 32'(e.diff));
            check("bout", 32'(bout), 32'(e.bout));
            check("done_cycle", cyc, e.cyc);
            check("busy_cycles", busy_cnt, WIDTH);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            check("ovf", 32'(ovf), 32'(e.ovf));
`endif
         end
         check("busy_during_done", 32'(busy), 32'd0);
         dones    = dones + 1;
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt = busy_cnt + 1;
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 50 && (busy || done); i++) begin
         @(posedge clk);
         #1;
      end
      check("wait_idle", 32'({busy, done}), 32'd0);
   endtask

   task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      wait_idle();
      a_in  = x;
      b_in  = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      q.push_back(model(x, y, cyc + WIDTH));
      accepts = accepts + 1;
      a_in = WIDTH'($urandom);
      b_in = WIDTH'($urandom);
   endtask

   initial begin
      int first_acc;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      checks = 0; errors = 0; cyc = 0; accepts = 0; dones = 0; busy_cnt = 0;
      start = 1'b0; a_in = '0; b_in = '0;
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed operand pairs.
      do_op(8'd100, 8'd37);
      do_op(8'd5, 8'd10);
      do_op(8'hFF, 8'hFF);
      do_op(8'h00, 8'h01);
      do_op(8'h00, 8'hFF);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      do_op(8'h80, 8'h01);
      do_op(8'h7F, 8'hFF);
      do_op(8'h10, 8'h05);
`endif

      // start held high, operands wandering during RUN.
      wait_idle();
      a_in = 8'd90; b_in = 8'd17; start = 1'b1;
      @(posedge clk);
      #1;
      first_acc = cyc;
      q.push_back(model(8'd90, 8'd17, first_acc + WIDTH));
      accepts = accepts + 1;
      for (int i = 0; i < 3 * WIDTH && !done; i++) begin
         a_in = WIDTH'($urandom);
         b_in = WIDTH'($urandom);
         @(posedge clk);
         #1;
      end
      a_in = 8'd33; b_in = 8'd200;
      // Second accept is in the cycle after done: WIDTH+2 edges after the first.
      q.push_back(model(8'd33, 8'd200, first_acc + (WIDTH + 2) + WIDTH));
      accepts = accepts + 1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;

      // Asynchronous reset in the middle of an operation.
      wait_idle();
      a_in = 8'd1; b_in = 8'd2; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (WIDTH + 3) @(posedge clk);
      #1;
      do_op(8'd200, 8'd55);

      // Random regression.
      for (int n = 0; n < 1000; n++) begin
         ra = WIDTH'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? ra : WIDTH'($urandom);
         do_op(ra, rb);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

      for (int i = 0; i < 50 && q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      check("queue_drained", q.size(), 0);
      check("done_count", dones, accepts);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_subtractor
